// File: rtl/uart_baudgen_frac.sv
// Fractional baud generator for the UART IP.
//
// Produces a one-cycle oversample tick (tick_os) every div_int or div_int+1
// clock cycles and a bit tick (tick_bit) on every OSR-th oversample tick. The
// effective divisor is div_int + div_frac/2^FRAC_W, realised by a FRAC_W-bit
// phase accumulator whose carry stretches a period by one cycle.
//
// Ports
//   clk          system clock
//   rst          synchronous reset, active-high, highest priority
//   en           run enable; 0 freezes counters and holds ticks low
//   sync_clr     restart the period and oversample phase (rx start-bit alignment)
//   cfg_wr       one-cycle request to load {div_int_in, div_frac_in}
//   div_int_in   requested integer divisor (must be >= 2)
//   div_frac_in  requested fractional divisor
//   cfg_busy     a written divisor is waiting for the next period boundary
//   cfg_err      one-cycle pulse: the last cfg_wr was rejected
//   tick_os      one-cycle oversample tick
//   tick_bit     one-cycle bit tick, coincident with tick_os
//   os_phase     oversample ticks completed in the current bit
module uart_baudgen_frac #(
    parameter int unsigned CLK_FREQ = 50_000_000,
    parameter int unsigned BAUD     = 9600,
    parameter int unsigned OSR      = 16,
    parameter int unsigned DIV_W    = 16,
    parameter int unsigned FRAC_W   = 4,
    parameter int unsigned DEF_INT  = CLK_FREQ / (BAUD * OSR),
    parameter int unsigned DEF_FRAC =
        int'(((longint'(CLK_FREQ) << FRAC_W) / longint'(BAUD * OSR)) % (longint'(1) << FRAC_W)),
    localparam int unsigned PH_W    = (OSR > 1) ? $clog2(OSR) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              sync_clr,
    input  logic              cfg_wr,
    input  logic [DIV_W-1:0]  div_int_in,
    input  logic [FRAC_W-1:0] div_frac_in,
    output logic              cfg_busy,
    output logic              cfg_err,
    output logic              tick_os,
    output logic              tick_bit,
    output logic [PH_W-1:0]   os_phase
);

    // Active divisor
    logic [DIV_W-1:0]  div_int_q, div_int_d;
    logic [FRAC_W-1:0] div_frac_q, div_frac_d;
    // Period counter and its terminal value for the current period
    logic [DIV_W-1:0]  cnt_q, cnt_d;
    logic [DIV_W-1:0]  lim_q, lim_d;
    logic [FRAC_W-1:0] acc_q, acc_d;
    logic [PH_W-1:0]   ph_q, ph_d;
    // Shadow divisor waiting for a period boundary
    logic [DIV_W-1:0]  sh_int_q, sh_int_d;
    logic [FRAC_W-1:0] sh_frac_q, sh_frac_d;
    logic              pend_q, pend_d;
    logic              err_q, err_d;
    logic              tick_os_q, tick_os_d;
    logic              tick_bit_q, tick_bit_d;

    logic [FRAC_W:0]   acc_sum;
    logic [DIV_W-1:0]  carry_ext;
    logic              at_lim;
    logic              wr_ok;

    always_comb begin
        acc_sum   = {1'b0, acc_q} + {1'b0, div_frac_q};
        carry_ext = {{(DIV_W-1){1'b0}}, acc_sum[FRAC_W]};
        at_lim    = (cnt_q == lim_q);
        wr_ok     = (div_int_in >= DIV_W'(2));
    end

    always_comb begin
        div_int_d  = div_int_q;
        div_frac_d = div_frac_q;
        cnt_d      = cnt_q;
        lim_d      = lim_q;
        acc_d      = acc_q;
        ph_d       = ph_q;
        sh_int_d   = sh_int_q;
        sh_frac_d  = sh_frac_q;
        pend_d     = pend_q;
        err_d      = 1'b0;
        tick_os_d  = 1'b0;
        tick_bit_d = 1'b0;

        if (sync_clr) begin
            cnt_d = '0;
            acc_d = '0;
            ph_d  = '0;
            if (pend_q) begin
                div_int_d  = sh_int_q;
                div_frac_d = sh_frac_q;
                lim_d      = sh_int_q - DIV_W'(1);
                pend_d     = 1'b0;
            end else begin
                lim_d = div_int_q - DIV_W'(1);
            end
        end else if (en) begin
            if (at_lim) begin
                cnt_d     = '0;
                tick_os_d = 1'b1;
                if (ph_q == PH_W'(OSR - 1)) begin
                    ph_d       = '0;
                    tick_bit_d = 1'b1;
                end else begin
                    ph_d = ph_q + PH_W'(1);
                end
                if (pend_q) begin
                    // New divisor takes effect for the following period,
                    // which starts at the plain integer length.
                    div_int_d  = sh_int_q;
                    div_frac_d = sh_frac_q;
                    acc_d      = '0;
                    lim_d      = sh_int_q - DIV_W'(1);
                    pend_d     = 1'b0;
                end else begin
                    acc_d = acc_sum[FRAC_W-1:0];
                    lim_d = div_int_q - DIV_W'(1) + carry_ext;
                end
            end else begin
                cnt_d = cnt_q + DIV_W'(1);
            end
        end else if (pend_q) begin
            // Frozen: apply at once. cnt restarts so it can never sit past a
            // shorter new limit.
            div_int_d  = sh_int_q;
            div_frac_d = sh_frac_q;
            cnt_d      = '0;
            acc_d      = '0;
            lim_d      = sh_int_q - DIV_W'(1);
            pend_d     = 1'b0;
        end

        // Evaluated after the apply logic so a write landing on the apply
        // cycle stays pending instead of being lost.
        if (cfg_wr) begin
            if (wr_ok) begin
                sh_int_d  = div_int_in;
                sh_frac_d = div_frac_in;
                pend_d    = 1'b1;
            end else begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_int_q  <= DIV_W'(DEF_INT);
            div_frac_q <= FRAC_W'(DEF_FRAC);
            cnt_q      <= '0;
            lim_q      <= DIV_W'(DEF_INT - 1);
            acc_q      <= '0;
            ph_q       <= '0;
            sh_int_q   <= '0;
            sh_frac_q  <= '0;
            pend_q     <= 1'b0;
            err_q      <= 1'b0;
            tick_os_q  <= 1'b0;
            tick_bit_q <= 1'b0;
        end else begin
            div_int_q  <= div_int_d;
            div_frac_q <= div_frac_d;
            cnt_q      <= cnt_d;
            lim_q      <= lim_d;
            acc_q      <= acc_d;
            ph_q       <= ph_d;
            sh_int_q   <= sh_int_d;
            sh_frac_q  <= sh_frac_d;
            pend_q     <= pend_d;
            err_q      <= err_d;
            tick_os_q  <= tick_os_d;
            tick_bit_q <= tick_bit_d;
        end
    end

    always_comb begin
        cfg_busy = pend_q;
        cfg_err  = err_q;
        tick_os  = tick_os_q;
        tick_bit = tick_bit_q;
        os_phase = ph_q;
    end

endmodule
